// File: rtl/io_pwr_seq_ctrl.sv
// rtl/io_pwr_seq_ctrl.sv - EG1D80V pad-ring power sequencer; optional supply-wait timeout via IO_PWR_SEQ_TIMEOUT_EN
module io_pwr_seq_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 16,
    parameter int ISO_DELAY      = 4,
    parameter int CNT_W          = 12,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vdd_ok_a,
    input  logic       vddio_ok_a,
    input  logic       seq_req_i,
    input  logic       fault_clr_i,
    output logic       pad_iso_o,
    output logic       pad_ie_en_o,
    output logic       pad_oe_en_o,
    output logic       pwr_good_o,
    output logic       fault_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_WAIT  = 3'd1,
        S_REL   = 3'd2,
        S_EN    = 3'd3,
        S_ON    = 3'd4,
        S_SHDN  = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] C_STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ISO_LAST    = CNT_W'(ISO_DELAY - 1);
    localparam logic [CNT_W-1:0] C_ONE         = CNT_W'(1);
`ifdef IO_PWR_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] C_TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    // Reject parameter sets the shared counter or synchronizer cannot support
    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || STABLE_CYCLES < 1 || ISO_DELAY < 1 ||
            (2 ** CNT_W) <= STABLE_CYCLES || (2 ** CNT_W) <= ISO_DELAY ||
            (2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cfg
            $error("io_pwr_seq_ctrl: illegal parameter set");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] r_vdd_sync;
    logic [SYNC_STAGES-1:0] r_vddio_sync;
    logic                   w_sup_ok;
    state_t                 r_state;
    state_t                 w_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   r_iso, r_ie, r_oe, r_pg, r_fault;
    logic                   w_iso, w_ie, w_oe, w_pg, w_fault;

    // Independent synchronizer chains for the two asynchronous supply-good flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vdd_sync   <= '0;
            r_vddio_sync <= '0;
        end else begin
            r_vdd_sync   <= {r_vdd_sync[SYNC_STAGES-2:0], vdd_ok_a};
            r_vddio_sync <= {r_vddio_sync[SYNC_STAGES-2:0], vddio_ok_a};
        end
    end

    assign w_sup_ok = r_vdd_sync[SYNC_STAGES-1] & r_vddio_sync[SYNC_STAGES-1];

    // Next-state and shared counter; the counter clears whenever it is not actively timing
    always_comb begin
        w_next     = r_state;
        w_cnt_next = '0;
        case (r_state)
            S_OFF: begin
                if (seq_req_i && w_sup_ok) begin
                    w_next = S_WAIT;
                end
`ifdef IO_PWR_SEQ_TIMEOUT_EN
                else if (seq_req_i) begin
                    if (r_cnt == C_TO_LAST) begin
                        w_next = S_FAULT;
                    end else begin
                        w_cnt_next = r_cnt + C_ONE;
                    end
                end
`endif
            end
            S_WAIT: begin
                if (!w_sup_ok || !seq_req_i) begin
                    w_next = S_OFF;
                end else if (r_cnt == C_STABLE_LAST) begin
                    w_next = S_REL;
                end else begin
                    w_cnt_next = r_cnt + C_ONE;
                end
            end
            S_REL: begin
                if (!w_sup_ok) begin
                    w_next = S_FAULT;
                end else if (!seq_req_i) begin
                    w_next = S_SHDN;
                end else if (r_cnt == C_ISO_LAST) begin
                    w_next = S_EN;
                end else begin
                    w_cnt_next = r_cnt + C_ONE;
                end
            end
            S_EN, S_ON: begin
                if (!w_sup_ok) begin
                    w_next = S_FAULT;
                end else if (!seq_req_i) begin
                    w_next = S_SHDN;
                end else begin
                    w_next = S_ON;
                end
            end
            S_SHDN: begin
                w_next = S_OFF;
            end
            S_FAULT: begin
                if (fault_clr_i && !seq_req_i) begin
                    w_next = S_OFF;
                end
            end
            default: begin
                w_next = S_FAULT;
            end
        endcase
    end

    // Pad-control decode of the state being entered, so registered outputs track state_o
    always_comb begin
        w_iso   = 1'b1;
        w_ie    = 1'b0;
        w_oe    = 1'b0;
        w_pg    = 1'b0;
        w_fault = 1'b0;
        case (w_next)
            S_REL, S_SHDN: begin
                w_iso = 1'b0;
                w_ie  = 1'b1;
            end
            S_EN: begin
                w_iso = 1'b0;
                w_ie  = 1'b1;
                w_oe  = 1'b1;
            end
            S_ON: begin
                w_iso = 1'b0;
                w_ie  = 1'b1;
                w_oe  = 1'b1;
                w_pg  = 1'b1;
            end
            S_FAULT: begin
                w_fault = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State, counter and glitch-free pad outputs; reset isolates the pads immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
            r_iso   <= 1'b1;
            r_ie    <= 1'b0;
            r_oe    <= 1'b0;
            r_pg    <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_iso   <= w_iso;
            r_ie    <= w_ie;
            r_oe    <= w_oe;
            r_pg    <= w_pg;
            r_fault <= w_fault;
        end
    end

    assign pad_iso_o   = r_iso;
    assign pad_ie_en_o = r_ie;
    assign pad_oe_en_o = r_oe;
    assign pwr_good_o  = r_pg;
    assign fault_o     = r_fault;
    assign state_o     = r_state;

endmodule

// File: tb/tb_io_pwr_seq_ctrl.sv
// tb/tb_io_pwr_seq_ctrl.sv - self-checking bench for io_pwr_seq_ctrl
module tb_io_pwr_seq_ctrl;

    localparam int SYNC    = 2;
    localparam int STABLE  = 16;
    localparam int ISO     = 4;
    localparam int CW      = 12;
    localparam int TIMEOUT = 1024;

    logic       clk;
    logic       rst_n;
    logic       vdd_ok_a;
    logic       vddio_ok_a;
    logic       seq_req_i;
    logic       fault_clr_i;
    logic       pad_iso_o;
    logic       pad_ie_en_o;
    logic       pad_oe_en_o;
    logic       pwr_good_o;
    logic       fault_o;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_errors = 0;

    io_pwr_seq_ctrl #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .ISO_DELAY     (ISO),
        .CNT_W         (CW),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vdd_ok_a   (vdd_ok_a),
        .vddio_ok_a (vddio_ok_a),
        .seq_req_i  (seq_req_i),
        .fault_clr_i(fault_clr_i),
        .pad_iso_o  (pad_iso_o),
        .pad_ie_en_o(pad_ie_en_o),
        .pad_oe_en_o(pad_oe_en_o),
        .pwr_good_o (pwr_good_o),
        .fault_o    (fault_o),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ring mode plus elapsed cycles since the power-up began
    localparam int M_OFF = 0, M_UP = 1, M_SHDN = 2, M_FAULT = 3;
    int              m_mode = M_OFF;
    int              m_t    = 0;
`ifdef IO_PWR_SEQ_TIMEOUT_EN
    int              m_to   = 0;
`endif
    logic [SYNC-1:0] m_hist = '0;
    logic            m_sup;
    assign m_sup = m_hist[SYNC-1];

    function automatic int up_code(input int t);
        if (t < STABLE) return 1;
        if (t < STABLE + ISO) return 2;
        if (t == STABLE + ISO) return 3;
        return 4;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= M_OFF;
            m_t    <= 0;
            m_hist <= '0;
`ifdef IO_PWR_SEQ_TIMEOUT_EN
            m_to   <= 0;
`endif
        end else begin
            m_hist <= {m_hist[SYNC-2:0], vdd_ok_a & vddio_ok_a};
`ifdef IO_PWR_SEQ_TIMEOUT_EN
            m_to   <= 0;
`endif
            case (m_mode)
                M_OFF: begin
                    if (seq_req_i && m_sup) begin
                        m_mode <= M_UP;
                        m_t    <= 0;
                    end
`ifdef IO_PWR_SEQ_TIMEOUT_EN
                    else if (seq_req_i) begin
                        if (m_to == TIMEOUT - 1) m_mode <= M_FAULT;
                        else m_to <= m_to + 1;
                    end
`endif
                end
                M_UP: begin
                    if (up_code(m_t) == 1) begin
                        if (!m_sup || !seq_req_i) m_mode <= M_OFF;
                        else m_t <= m_t + 1;
                    end else if (!m_sup) begin
                        m_mode <= M_FAULT;
                    end else if (!seq_req_i) begin
                        m_mode <= M_SHDN;
                    end else if (m_t < 1000) begin
                        m_t <= m_t + 1;
                    end
                end
                M_SHDN: m_mode <= M_OFF;
                default: begin
                    if (fault_clr_i && !seq_req_i) m_mode <= M_OFF;
                end
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        int e_st;
        logic e_iso, e_ie, e_oe, e_pg, e_f;
        e_st = 0; e_iso = 1'b1; e_ie = 1'b0; e_oe = 1'b0; e_pg = 1'b0; e_f = 1'b0;
        case (m_mode)
            M_UP: begin
                e_st = up_code(m_t);
                if (e_st >= 2) begin e_iso = 1'b0; e_ie = 1'b1; end
                if (e_st >= 3) e_oe = 1'b1;
                if (e_st == 4) e_pg = 1'b1;
            end
            M_SHDN: begin e_st = 5; e_iso = 1'b0; e_ie = 1'b1; end
            M_FAULT: begin e_st = 6; e_f = 1'b1; end
            default: begin end
        endcase
        check("mdl_state", state_o, e_st);
        check("mdl_iso", pad_iso_o, e_iso);
        check("mdl_ie", pad_ie_en_o, e_ie);
        check("mdl_oe", pad_oe_en_o, e_oe);
        check("mdl_pg", pwr_good_o, e_pg);
        check("mdl_fault", fault_o, e_f);
    end

    // Called at posedge+1; advances until state_o equals code or the budget expires
    task automatic wait_state(input string name, input int code, input int max_cyc, output int cyc);
        cyc = 0;
        while (state_o !== code[2:0] && cyc < max_cyc) begin
            @(posedge clk); #1;
            cyc++;
        end
        check(name, state_o, code);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_n = 1'b0; vdd_ok_a = 1'b0; vddio_ok_a = 1'b0; seq_req_i = 1'b0; fault_clr_i = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("rst_iso", pad_iso_o, 1);
        check("rst_ie", pad_ie_en_o, 0);
        check("rst_oe", pad_oe_en_o, 0);
        check("rst_pg", pwr_good_o, 0);
        check("rst_fault", fault_o, 0);
        check("rst_state", state_o, 0);
        @(negedge clk) rst_n = 1'b1;

        // Power-up latency
        vdd_ok_a = 1'b1; vddio_ok_a = 1'b1;
        repeat (4) @(negedge clk);
        seq_req_i = 1'b1;
        @(posedge clk); #1;
        check("up_wait_at_k", state_o, 1);
        repeat (15) @(posedge clk); #1;
        check("up_iso_k15", pad_iso_o, 1);
        @(posedge clk); #1;
        check("up_iso_k16", pad_iso_o, 0);
        check("up_rel_k16", state_o, 2);
        repeat (3) @(posedge clk); #1;
        check("up_oe_k19", pad_oe_en_o, 0);
        @(posedge clk); #1;
        check("up_oe_k20", pad_oe_en_o, 1);
        check("up_en_k20", state_o, 3);
        @(posedge clk); #1;
        check("up_pg_k21", pwr_good_o, 1);
        check("up_on_k21", state_o, 4);

        // Power-down ordering
        repeat (3) @(posedge clk);
        @(negedge clk) seq_req_i = 1'b0;
        @(posedge clk); #1;
        check("dn_shdn", state_o, 5);
        check("dn_oe_off", pad_oe_en_o, 0);
        check("dn_iso_still_off", pad_iso_o, 0);
        @(posedge clk); #1;
        check("dn_off", state_o, 0);
        check("dn_iso_on", pad_iso_o, 1);

        // Supply glitch during WAIT
        @(negedge clk) seq_req_i = 1'b1;
        @(posedge clk); #1;
        check("gl_wait", state_o, 1);
        repeat (10) @(posedge clk);
        @(negedge clk) vddio_ok_a = 1'b0;
        repeat (5) @(negedge clk);
        vddio_ok_a = 1'b1;
        @(posedge clk); #1;
        wait_state("gl_back_off", 0, 10, c);
        check("gl_no_fault", fault_o, 0);
        wait_state("gl_rewait", 1, 20, c);
        wait_state("gl_rel", 2, 40, c);
        check("gl_full_wait", c, STABLE);
        wait_state("gl_on", 4, 30, c);

        // Simultaneous supply loss and request drop: fault wins
        @(negedge clk) vdd_ok_a = 1'b0;
        repeat (SYNC) @(negedge clk);
        seq_req_i = 1'b0;
        @(posedge clk); #1;
        check("fp_state", state_o, 6);
        check("fp_fault", fault_o, 1);
        check("fp_iso", pad_iso_o, 1);
        @(negedge clk) begin vdd_ok_a = 1'b1; seq_req_i = 1'b1; fault_clr_i = 1'b1; end
        @(negedge clk) fault_clr_i = 1'b0;
        @(posedge clk); #1;
        check("fp_clr_ignored", state_o, 6);
        @(negedge clk) begin seq_req_i = 1'b0; fault_clr_i = 1'b1; end
        @(posedge clk); #1;
        check("fp_cleared_state", state_o, 0);
        check("fp_cleared_fault", fault_o, 0);
        @(negedge clk) fault_clr_i = 1'b0;

        // Asynchronous reset in REL
        @(negedge clk) seq_req_i = 1'b1;
        @(posedge clk); #1;
        wait_state("ar_rel", 2, 40, c);
        #2 rst_n = 1'b0;
        #1;
        check("ar_iso_async", pad_iso_o, 1);
        check("ar_ie_async", pad_ie_en_o, 0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("ar_off_after", state_o, 0);
        @(negedge clk) seq_req_i = 1'b0;

        // Supplies absent with request held
        vdd_ok_a = 1'b0; vddio_ok_a = 1'b0;
        repeat (3) @(negedge clk);
        seq_req_i = 1'b1;
`ifdef IO_PWR_SEQ_TIMEOUT_EN
        repeat (TIMEOUT - 1) @(posedge clk); #1;
        check("to_not_yet", fault_o, 0);
        @(posedge clk); #1;
        check("to_fault", fault_o, 1);
        repeat (2000 - TIMEOUT) @(posedge clk); #1;
        check("to_state", state_o, 6);
`else
        repeat (2000) @(posedge clk); #1;
        check("nto_state", state_o, 0);
        check("nto_fault", fault_o, 0);
`endif
        @(negedge clk) begin seq_req_i = 1'b0; fault_clr_i = 1'b1; end
        @(negedge clk) fault_clr_i = 1'b0;

        // Randomized traffic against the model
        vdd_ok_a = 1'b1; vddio_ok_a = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            fault_clr_i = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 59) == 0) seq_req_i = ~seq_req_i;
            if (!vdd_ok_a) begin
                if ($urandom_range(0, 7) == 0) vdd_ok_a = 1'b1;
            end else if ($urandom_range(0, 149) == 0) vdd_ok_a = 1'b0;
            if (!vddio_ok_a) begin
                if ($urandom_range(0, 7) == 0) vddio_ok_a = 1'b1;
            end else if ($urandom_range(0, 149) == 0) vddio_ok_a = 1'b0;
            if ($urandom_range(0, 999) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
